// File: rtl/tinyqv_qspi_pkg.sv
// Constants and state encoding shared by the TinyQV QSPI controller and RAM target.
package tinyqv_qspi_pkg;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/tinyqv_sync_edge.sv
// Two-flop synchronizer with one-clk rise/fall pulses taken from the synchronized level.
module tinyqv_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/tinyqv_qspi_ram_target.sv
// Quad-SPI RAM responder: decodes host frames in the clk domain and serves them from a byte-wide memory port.
module tinyqv_qspi_ram_target
  import tinyqv_qspi_pkg::*;
#(
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk_in,
  input  logic                 spi_cs_n,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 busy
);

  localparam int ADDR_NIBS = (ADDR_BITS + 3) / 4;
  localparam int CNT_W     = 8;

  logic                 sclk_rise, sclk_fall;
  logic                 csn_s1_q, csn_q;
  logic [3:0]           din_s1_q, din_q;
  logic [1:0]           prime_q;
  logic                 desel_q;
  qspi_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           hi_q;
  logic                 is_wr_q, lo_q;
  logic [ADDR_BITS-1:0] addr_q, addr_inc_d;
  logic [7:0]           rbuf_q, rbyte_d, wdata_q;
  logic                 rd_cap_q, mem_re_q, mem_we_q;
  logic [3:0]           dout_q, oe_q;

  tinyqv_sync_edge u_sclk (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (spi_clk_in),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign addr_inc_d = addr_q + ADDR_BITS'(1);
  // Forward the RAM byte in the cycle it arrives so a tight fall still sees fresh data.
  assign rbyte_d    = rd_cap_q ? mem_rdata : rbuf_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      csn_s1_q <= 1'b1;
      csn_q    <= 1'b1;
      din_s1_q <= 4'h0;
      din_q    <= 4'h0;
      prime_q  <= 2'b00;
      desel_q  <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= 4'h0;
      is_wr_q  <= 1'b0;
      lo_q     <= 1'b0;
      addr_q   <= '0;
      rbuf_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rd_cap_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      dout_q   <= 4'h0;
      oe_q     <= 4'h0;
    end else begin
      csn_s1_q <= spi_cs_n;
      csn_q    <= csn_s1_q;
      din_s1_q <= spi_data_in;
      din_q    <= din_s1_q;
      prime_q  <= {prime_q[0], 1'b1};
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      rd_cap_q <= mem_re_q;
      if (rd_cap_q) rbuf_q <= mem_rdata;
      if (mem_we_q) addr_q <= addr_inc_d;

      // desel_q only sets once the sync chain holds real pin values, so a host
      // already selected at reset release lands in IGNORE rather than CMD.
      if (prime_q[1] && csn_q) begin
        state_q  <= ST_IDLE;
        desel_q  <= 1'b1;
        cnt_q    <= '0;
        lo_q     <= 1'b0;
        rd_cap_q <= 1'b0;
        oe_q     <= 4'h0;
        dout_q   <= 4'h0;
      end else if (prime_q[1]) begin
        case (state_q)
          ST_IDLE: begin
            state_q <= desel_q ? ST_CMD : ST_IGNORE;
            cnt_q   <= '0;
          end
          ST_CMD: if (sclk_rise) begin
            if (cnt_q == '0) begin
              hi_q  <= din_q;
              cnt_q <= CNT_W'(1);
            end else begin
              cnt_q <= '0;
              if ({hi_q, din_q} == CMD_READ) begin
                state_q <= ST_ADDR;
                is_wr_q <= 1'b0;
              end else if ({hi_q, din_q} == CMD_WRITE) begin
                state_q <= ST_ADDR;
                is_wr_q <= 1'b1;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: if (sclk_rise) begin
            addr_q <= ADDR_BITS'({addr_q, din_q});
            if (cnt_q == CNT_W'(ADDR_NIBS - 1)) begin
              cnt_q <= '0;
              lo_q  <= 1'b0;
              if (is_wr_q) begin
                state_q <= ST_WRITE;
              end else begin
                mem_re_q <= 1'b1;
                state_q  <= (DUMMY_CYCLES == 0) ? ST_READ : ST_DUMMY;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_DUMMY: if (sclk_rise) begin
            if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_READ;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_READ: if (sclk_fall) begin
            oe_q <= 4'hF;
            if (!lo_q) begin
              dout_q <= rbyte_d[7:4];
              lo_q   <= 1'b1;
            end else begin
              dout_q   <= rbyte_d[3:0];
              lo_q     <= 1'b0;
              addr_q   <= addr_inc_d;
              mem_re_q <= 1'b1;
            end
          end
          ST_WRITE: if (sclk_rise) begin
            if (!lo_q) begin
              hi_q <= din_q;
              lo_q <= 1'b1;
            end else begin
              wdata_q  <= {hi_q, din_q};
              mem_we_q <= 1'b1;
              lo_q     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_data_out = dout_q;
  assign spi_data_oe  = csn_q ? 4'h0 : oe_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
